// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a bounded grant length.
//
// State table
//   state | meaning
//   IDLE  | no grant outstanding, arbitrate on any request
//   GRANT | one requester holds the grant, timer running
//   GAP   | one dead cycle after a grant, arbitrate again
//
// Ports
//   clk         : single clock, all state changes on posedge
//   rst_n       : synchronous active-low reset
//   req[N]      : per-requester request level
//   done[N]     : per-requester completion pulse (only the holder's bit counts)
//   gnt[N]      : registered one-hot grant
//   gnt_id      : registered index of the holder, held outside GRANT
//   busy        : high while in GRANT
//   timeout_err : one-cycle pulse in the GAP that follows a timed-out grant
module rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic [IW-1:0] gnt_id_nx;
  logic [7:0]    timer, timer_nx;
  logic [N-1:0]  gnt_nx;
  logic          busy_nx;
  logic          terr_nx;
  logic          release_c;
  logic          expire_c;

  // Scan offsets from the far end down to ptr+1 so the nearest set
  // request after ptr is the last one written and therefore wins.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) win = idx;
    end
  end

  assign release_c = done[gnt_id] | ~req[gnt_id];
  assign expire_c  = (timer == 8'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    gnt_nx    = '0;
    gnt_id_nx = gnt_id;
    busy_nx   = 1'b0;
    terr_nx   = 1'b0;
    timer_nx  = timer;
    ptr_nx    = ptr;
    case (state)
      IDLE, GAP: begin
        if (|req) begin
          state_nx  = GRANT;
          gnt_nx    = N'(1) << win;
          gnt_id_nx = win;
          busy_nx   = 1'b1;
          timer_nx  = '0;
          ptr_nx    = win;
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT: begin
        if (release_c || expire_c) begin
          state_nx = GAP;
          // a release on the expiry cycle is a normal release, not an error
          terr_nx  = ~release_c;
        end else begin
          gnt_nx   = gnt;
          busy_nx  = 1'b1;
          timer_nx = timer + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_id      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      timer       <= '0;
      ptr         <= IW'(N - 1);
    end else begin
      state       <= state_nx;
      gnt         <= gnt_nx;
      gnt_id      <= gnt_id_nx;
      busy        <= busy_nx;
      timeout_err <= terr_nx;
      timer       <= timer_nx;
      ptr         <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a behavioural model of the arbitration rules.
module tb_rr_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;
  localparam int IW      = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout_err;

  rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // model: who holds the grant (-1 none), how many cycles it has held it,
  // who won last, last reported index, expected timeout pulse
  int m_holder = -1;
  int m_age    = 0;
  int m_last   = N - 1;
  int m_id     = 0;
  bit m_terr   = 1'b0;

  int order[$];
  bit prev_busy  = 1'b0;
  int terr_seen  = 0;

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  task automatic model_step();
    bit rel;
    int c;
    if (!rst_n) begin
      m_holder = -1; m_age = 0; m_last = N - 1; m_id = 0; m_terr = 1'b0;
    end else if (m_holder >= 0) begin
      rel = done[m_holder] || !req[m_holder];
      if (rel || m_age == TIMEOUT - 1) begin
        m_terr   = !rel;
        m_holder = -1;
      end else begin
        m_age++;
        m_terr = 1'b0;
      end
    end else begin
      m_terr = 1'b0;
      if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (req[c]) begin
            m_holder = c;
            break;
          end
        end
        m_id   = m_holder;
        m_last = m_holder;
        m_age  = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]  e_gnt;
    logic [IW-1:0] e_id;
    logic          e_busy;
    e_gnt  = (m_holder >= 0) ? onehot(m_holder) : '0;
    e_id   = IW'(m_id);
    e_busy = (m_holder >= 0);
    vectors++;
    assert (gnt === e_gnt) else begin
      miscompares++;
      $error("FAIL gnt observed=%b expected=%b", gnt, e_gnt);
    end
    vectors++;
    assert (gnt_id === e_id) else begin
      miscompares++;
      $error("FAIL gnt_id observed=%0d expected=%0d", gnt_id, e_id);
    end
    vectors++;
    assert (busy === e_busy) else begin
      miscompares++;
      $error("FAIL busy observed=%b expected=%b", busy, e_busy);
    end
    vectors++;
    assert (timeout_err === m_terr) else begin
      miscompares++;
      $error("FAIL timeout_err observed=%b expected=%b", timeout_err, m_terr);
    end
    if (busy && !prev_busy) order.push_back(int'(gnt_id));
    prev_busy = busy;
    if (timeout_err) terr_seen++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d, input logic rn);
    req = r; done = d; rst_n = rn;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] d;
    logic         rn;
    int           exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    req = '0; done = '0; rst_n = 1'b0;

    // reset state
    do_reset();
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_gnt_id", int'(gnt_id), 0);

    // all requesting, each holder completes on its third cycle
    order.delete();
    for (int i = 0; i < 20; i++) begin
      d = (m_holder >= 0 && m_age == 2) ? onehot(m_holder) : '0;
      cyc(4'b1111, d, 1'b1);
    end
    chk("rr_order_count", (order.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (order.size() > i) ? order[i] : -1, exp_order[i]);

    // lone requester that never completes: times out, then re-granted
    do_reset();
    terr_seen = 0;
    for (int i = 0; i < 16; i++) cyc(4'b0100, '0, 1'b1);
    chk("hold_16_gnt", int'(gnt), 4);
    cyc(4'b0100, '0, 1'b1);
    chk("timeout_pulse", int'(timeout_err), 1);
    chk("timeout_gap_gnt", int'(gnt), 0);
    cyc(4'b0100, '0, 1'b1);
    chk("timeout_single_pulse", int'(timeout_err), 0);
    chk("regrant_2", int'(gnt), 4);
    chk("timeout_count", terr_seen, 1);

    // dropping req releases into GAP, pending requester follows
    do_reset();
    cyc(4'b0010, '0, 1'b1);
    cyc(4'b1010, '0, 1'b1);
    cyc(4'b1000, '0, 1'b1);
    chk("drop_gap_gnt", int'(gnt), 0);
    chk("drop_gap_terr", int'(timeout_err), 0);
    cyc(4'b1000, '0, 1'b1);
    chk("drop_next_id", int'(gnt_id), 3);

    // done on the final timer cycle is a release, not a timeout
    do_reset();
    terr_seen = 0;
    for (int i = 0; i < 40; i++) begin
      d = (m_holder == 2 && m_age == TIMEOUT - 1) ? 4'b0100 : '0;
      cyc(4'b0100, d, 1'b1);
    end
    chk("late_done_no_timeout", terr_seen, 0);

    // reset during a grant revokes it and restores requester-0 priority
    do_reset();
    cyc(4'b0100, '0, 1'b1);
    cyc(4'b0100, '0, 1'b1);
    cyc(4'b0100, '0, 1'b0);
    chk("rst_mid_gnt", int'(gnt), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_id", int'(gnt_id), 0);
    cyc(4'b1100, '0, 1'b1);
    chk("rst_first_id", int'(gnt_id), 2);

    // done from a non-holder is ignored
    do_reset();
    cyc(4'b0001, '0, 1'b1);
    cyc(4'b0001, 4'b1000, 1'b1);
    cyc(4'b0001, '0, 1'b1);
    cyc(4'b0001, 4'b1000, 1'b1);
    chk("foreign_done_gnt", int'(gnt), 1);

    // random traffic against the model
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      d = '0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(31) == 0) d = d | onehot(b);
      rn = ($urandom_range(199) != 0);
      cyc(r, d, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
